// File: rtl/dcache_mem_array_if.sv
// ---------------------------------------------------------------------------
// dcache_mem_array_if
// Bundles the write, read and status signals of dcache_mem_array.
// Each flattened bus holds port p in slice [p*W +: W].
//   wr_valid        NWR            per-port write request
//   wr_addr         NWR*64         per-port word address (low ADDR_W bits used)
//   wr_data         NWR*DATA_W     per-port write data
//   wr_be           NWR*DATA_W/8   per-port byte enables
//   wr_ready        1              writes accepted (clear sweep finished)
//   rd_addr         NRD*64         per-port read address (low ADDR_W bits used)
//   rd_data         NRD*DATA_W     per-port combinational read data
//   init_busy       1              clear sweep in progress
//   wr_conflict_cnt 16             saturating conflicting-write cycle count
// Modports: master drives requests, slave is the storage array.
// ---------------------------------------------------------------------------
interface dcache_mem_array_if #(
  parameter int DATA_W = 64,
  parameter int NRD    = 4,
  parameter int NWR    = 2
);
  localparam int NB = DATA_W / 8;

  logic [NWR-1:0]        wr_valid;
  logic [NWR*64-1:0]     wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic [NWR*NB-1:0]     wr_be;
  logic                  wr_ready;
  logic [NRD*64-1:0]     rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  init_busy;
  logic [15:0]           wr_conflict_cnt;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_be, rd_addr,
    input  wr_ready, rd_data, init_busy, wr_conflict_cnt
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_be, rd_addr,
    output wr_ready, rd_data, init_busy, wr_conflict_cnt
  );
endinterface

// File: rtl/dcache_mem_array.sv
// ---------------------------------------------------------------------------
// dcache_mem_array
// Parametrised multi-port data-cache storage array with per-byte write
// enables, fixed write-port priority (higher port index wins), a clear
// sweep after reset and a saturating write-conflict counter.
//
// Ports:
//   clk    clock, all state updates on posedge
//   reset  synchronous active-high reset; starts the clear sweep
//   bus    dcache_mem_array_if.slave (write/read ports and status)
//
// Optional feature: define DCACHE_WR_BYPASS_EN to forward same-cycle
// accepted writes onto rd_data (per byte, highest enabling port wins).
// Without it, a written value appears on rd_data after the clock edge.
// ---------------------------------------------------------------------------
module dcache_mem_array #(
  parameter int  DATA_W = 64,
  parameter int  DEPTH  = 2048,
  parameter int  NRD    = 4,
  parameter int  NWR    = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               reset,
  dcache_mem_array_if.slave bus
);
  localparam int NB = DATA_W / 8;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [15:0]       conflict_cnt_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] waddr [NWR];
  logic [ADDR_W-1:0] raddr [NRD];
  logic [DATA_W-1:0] rd_word [NRD];
  logic              addr_hi_unused;
  logic              busy;
  logic              conflict;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Only the low ADDR_W bits of each 64-bit address index the array.
  always_comb begin
    addr_hi_unused = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      waddr[p] = bus.wr_addr[p*64 +: ADDR_W];
      addr_hi_unused = addr_hi_unused ^ (^bus.wr_addr[p*64+ADDR_W +: 64-ADDR_W]);
    end
    for (int r = 0; r < NRD; r++) begin
      raddr[r] = bus.rd_addr[r*64 +: ADDR_W];
      addr_hi_unused = addr_hi_unused ^ (^bus.rd_addr[r*64+ADDR_W +: 64-ADDR_W]);
    end
  end

  // Reset forces the busy view immediately, before the first edge settles state.
  assign busy = reset || (state_q == CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= CLEAR;
      clr_idx_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      if (conflict) begin
        conflict_cnt_q <= sat_inc16(conflict_cnt_q);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  // A cycle counts once if any two accepted ports touch a common byte of one index.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (bus.wr_valid[i] && bus.wr_valid[j] && (waddr[i] == waddr[j]) &&
            |(bus.wr_be[i*NB +: NB] & bus.wr_be[j*NB +: NB])) begin
          conflict = 1'b1;
        end
      end
    end
    if (busy) begin
      conflict = 1'b0;
    end
  end

  // Ports are applied in ascending order, so the last (highest) enabling
  // port's byte is the one that lands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem[clr_idx_q] <= '0;
      end else begin
        for (int p = 0; p < NWR; p++) begin
          for (int b = 0; b < NB; b++) begin
            if (bus.wr_valid[p] && bus.wr_be[p*NB + b]) begin
              mem[waddr[p]][b*8 +: 8] <= bus.wr_data[p*DATA_W + b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int r = 0; r < NRD; r++) begin
      rd_word[r] = mem[raddr[r]];
`ifdef DCACHE_WR_BYPASS_EN
      for (int p = 0; p < NWR; p++) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.wr_valid[p] && bus.wr_be[p*NB + b] && (waddr[p] == raddr[r])) begin
            rd_word[r][b*8 +: 8] = bus.wr_data[p*DATA_W + b*8 +: 8];
          end
        end
      end
`endif
      bus.rd_data[r*DATA_W +: DATA_W] = busy ? '0 : rd_word[r];
    end
  end

  assign bus.init_busy       = busy;
  assign bus.wr_ready        = !busy;
  assign bus.wr_conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_dcache_mem_array.sv
// ---------------------------------------------------------------------------
// tb_dcache_mem_array
// Scoreboard bench for dcache_mem_array. Each cycle the driver applies
// stimulus, asks a byte-level reference model for the expected outputs and
// queues them; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dcache_mem_array;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 2048;
  localparam int NRD    = 4;
  localparam int NWR    = 2;
  localparam int NB     = DATA_W / 8;
  localparam int ADDR_W = $clog2(DEPTH);
`ifdef DCACHE_WR_BYPASS_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_mem_array_if #(.DATA_W(DATA_W), .NRD(NRD), .NWR(NWR)) bus();

  dcache_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          kind;   // 0 rd_data, 1 init_busy, 2 wr_ready, 3 conflict count
    int          port;
    int          tag;    // 0 = model check, >0 = directed check id
    logic [63:0] exp;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  logic [63:0] act;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus for the current cycle
  logic              s_reset;
  logic [NWR-1:0]    s_wv;
  logic [63:0]       s_wa [NWR];
  logic [63:0]       s_wd [NWR];
  logic [NB-1:0]     s_be [NWR];
  logic [63:0]       s_ra [NRD];

  // Reference model: the array as plain bytes, a pending-clear counter and
  // the conflict count as an integer.
  logic [7:0] mref [DEPTH*NB];
  int clear_left = 0;
  int mcnt = 0;
  bit chk_en = 1'b0;

  function automatic int aidx(logic [63:0] a);
    return int'(a % 64'(DEPTH));
  endfunction

  function automatic string kname(int k);
    case (k)
      0: return "rd_data";
      1: return "init_busy";
      2: return "wr_ready";
      default: return "wr_conflict_cnt";
    endcase
  endfunction

  function automatic logic [63:0] mdl_read(int a);
    logic [63:0] w;
    for (int b = 0; b < NB; b++) w[b*8 +: 8] = mref[a*NB + b];
    if (FWD) begin
      for (int p = 0; p < NWR; p++)
        if (s_wv[p] && aidx(s_wa[p]) == a)
          for (int b = 0; b < NB; b++)
            if (s_be[p][b]) w[b*8 +: 8] = s_wd[p][b*8 +: 8];
    end
    return w;
  endfunction

  task automatic push(int kind, int port, logic [63:0] v, int tag);
    exp_t e;
    e.kind = kind; e.port = port; e.exp = v; e.tag = tag; e.cyc = cyc;
    sbq.push_back(e);
  endtask

  // Apply stimulus for one cycle, queue the model's expectations, then
  // advance the model past the closing edge.
  task automatic cyc_go();
    bit busy;
    bit conf;
    int hits [int];
    @(posedge clk); #1;
    reset = s_reset;
    bus.wr_valid = s_wv;
    for (int p = 0; p < NWR; p++) begin
      bus.wr_addr[p*64 +: 64]         = s_wa[p];
      bus.wr_data[p*DATA_W +: DATA_W] = s_wd[p];
      bus.wr_be[p*NB +: NB]           = s_be[p];
    end
    for (int r = 0; r < NRD; r++) bus.rd_addr[r*64 +: 64] = s_ra[r];

    busy = s_reset || (clear_left > 0);
    if (chk_en) begin
      push(1, 0, 64'(busy), 0);
      push(2, 0, 64'(!busy), 0);
      push(3, 0, 64'(mcnt), 0);
      for (int r = 0; r < NRD; r++) push(0, r, busy ? 64'd0 : mdl_read(aidx(s_ra[r])), 0);
    end

    if (s_reset) begin
      clear_left = DEPTH;
      mcnt = 0;
      foreach (mref[i]) mref[i] = 8'h00;
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      conf = 1'b0;
      for (int p = 0; p < NWR; p++)
        if (s_wv[p])
          for (int b = 0; b < NB; b++)
            if (s_be[p][b]) begin
              if (hits.exists(aidx(s_wa[p]) * NB + b)) conf = 1'b1;
              else hits[aidx(s_wa[p]) * NB + b] = 1;
              mref[aidx(s_wa[p]) * NB + b] = s_wd[p][b*8 +: 8];
            end
      if (conf && mcnt < 65535) mcnt++;
    end
    chk_en = 1'b1;
  endtask

  function automatic logic [63:0] mk_addr(int idx);
    logic [63:0] hi;
    hi = {32'($urandom()), 32'($urandom())};
    return (hi << ADDR_W) | 64'(idx);
  endfunction

  task automatic no_writes();
    s_wv = '0;
    for (int p = 0; p < NWR; p++) begin
      s_wa[p] = '0; s_wd[p] = '0; s_be[p] = '0;
    end
  endtask

  task automatic rand_writes(int amax);
    for (int p = 0; p < NWR; p++) begin
      int sel;
      s_wv[p] = 1'($urandom_range(0, 1));
      s_wa[p] = mk_addr($urandom_range(0, amax));
      s_wd[p] = {32'($urandom()), 32'($urandom())};
      sel = $urandom_range(0, 3);
      s_be[p] = (sel == 0) ? '0 : (sel == 1) ? '1 : NB'($urandom());
    end
  endtask

  task automatic rand_reads(int amax);
    for (int r = 0; r < NRD; r++) s_ra[r] = mk_addr($urandom_range(0, amax));
  endtask

  task automatic set_wr(int p, int idx, logic [63:0] d, logic [NB-1:0] be);
    s_wv[p] = 1'b1; s_wa[p] = mk_addr(idx); s_wd[p] = d; s_be[p] = be;
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      me = sbq.pop_front();
      case (me.kind)
        0:       act = bus.rd_data[me.port*DATA_W +: DATA_W];
        1:       act = 64'(bus.init_busy);
        2:       act = 64'(bus.wr_ready);
        default: act = 64'(bus.wr_conflict_cnt);
      endcase
      checks++;
      if (me.cyc != cyc || act !== me.exp) begin
        errors++;
        $display("FAIL %s port=%0d tag=%0d cyc=%0d got=%h want=%h", kname(me.kind),
                 me.port, me.tag, me.cyc, act, me.exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    s_reset = 1'b1;
    no_writes();
    for (int r = 0; r < NRD; r++) s_ra[r] = '0;

    // Reset, then the full clear sweep with writes that must be dropped
    for (int i = 0; i < 3; i++) begin rand_reads(DEPTH-1); cyc_go(); end
    s_reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rand_writes(15); rand_reads(DEPTH-1); cyc_go();
    end
    no_writes(); rand_reads(15); cyc_go();
    push(1, 0, 64'd0, 1);
    push(2, 0, 64'd1, 1);

    // Every address reads zero after the sweep
    for (int i = 0; i < DEPTH / NRD; i++) begin
      for (int r = 0; r < NRD; r++) s_ra[r] = mk_addr(i*NRD + r);
      cyc_go();
    end

    // Byte-enable merge on addr 5 over two cycles
    set_wr(0, 5, 64'h1122334455667788, 8'hFF); cyc_go();
    no_writes(); set_wr(1, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F); cyc_go();
    no_writes(); s_ra[0] = mk_addr(5); cyc_go();
    push(0, 0, 64'h11223344AAAAAAAA, 2);

    // Full-overlap conflict on addr 9, then disjoint bytes
    set_wr(0, 9, 64'd1, 8'hFF); set_wr(1, 9, 64'd2, 8'hFF); s_ra[1] = mk_addr(9); cyc_go();
    no_writes(); cyc_go();
    push(0, 1, 64'd2, 3);
    push(3, 0, 64'd1, 3);
    set_wr(0, 9, 64'h1111111111111111, 8'h0F); set_wr(1, 9, 64'h2222222222222222, 8'hF0); cyc_go();
    no_writes(); cyc_go();
    push(0, 1, 64'h2222222211111111, 4);
    push(3, 0, 64'd1, 4);

    // Same-cycle read of a written index
    set_wr(0, 7, 64'hDEAD, 8'hFF); s_ra[0] = mk_addr(7); cyc_go();
    push(0, 0, FWD ? 64'hDEAD : 64'd0, 5);
    no_writes(); cyc_go();
    push(0, 0, 64'hDEAD, 6);

    // Randomised traffic over a small index range
    for (int i = 0; i < 2000; i++) begin
      rand_writes(15); rand_reads(15); cyc_go();
    end

    // Reset at clr_idx=1000 restarts the sweep; a write to addr 3 is dropped
    no_writes(); s_reset = 1'b1; cyc_go();
    s_reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      no_writes(); if (i == 500) set_wr(0, 3, 64'h5555AAAA5555AAAA, 8'hFF);
      rand_reads(15); cyc_go();
    end
    no_writes(); s_reset = 1'b1; cyc_go();
    s_reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      no_writes(); if (i == 10) set_wr(1, 3, 64'h0123456789ABCDEF, 8'hFF);
      rand_reads(15); cyc_go();
      if (i == DEPTH - 1) push(1, 0, 64'd1, 7);
    end
    no_writes(); s_ra[2] = mk_addr(3); cyc_go();
    push(1, 0, 64'd0, 8);
    push(0, 2, 64'd0, 8);

    // Counter saturation
    for (int i = 0; i < 65540; i++) begin
      set_wr(0, 9, 64'(i), 8'hFF); set_wr(1, 9, 64'(i + 1), 8'hFF); rand_reads(15); cyc_go();
    end
    no_writes(); cyc_go();
    push(3, 0, 64'hFFFF, 9);

    // Reset clears the counter
    s_reset = 1'b1; cyc_go();
    s_reset = 1'b0; cyc_go();
    push(3, 0, 64'd0, 10);
    push(1, 0, 64'd1, 10);

    @(negedge clk); @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
